operand_fetch_stage: RTL and testbench

//  Decode/operand-read stage sitting directly upstream of the register file
//  and feeding the EX stage. Drives the regfile read addresses, selects

---
 rtl/operand_fetch_stage_if.sv | 53 +++++
 rtl/operand_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_if.sv
// Bundle of the fetch beat, regfile read, forwarding network and ID/EX
// register signals seen by the operand fetch stage.
interface operand_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic            ex_fwd_wen;
  logic            ex_load;
  logic [4:0]      ex_fwd_rd;
  logic [XLEN-1:0] ex_fwd_data;
  logic            mem_fwd_wen;
  logic [4:0]      mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_wen;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;

  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [4:0]      ex_rd;

  modport slave (
    input  if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2,
           ex_fwd_wen, ex_load, ex_fwd_rd, ex_fwd_data,
           mem_fwd_wen, mem_fwd_rd, mem_fwd_data,
           wb_wen, wb_waddr, wb_wdata, flush, ex_ready,
    output id_ready, rf_raddr1, rf_raddr2,
           ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd
  );

  modport master (
    output if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2,
           ex_fwd_wen, ex_load, ex_fwd_rd, ex_fwd_data,
           mem_fwd_wen, mem_fwd_rd, mem_fwd_data,
           wb_wen, wb_waddr, wb_wdata, flush, ex_ready,
    input  id_ready, rf_raddr1, rf_raddr2,
           ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// ID stage: regfile addressing, EX/MEM/WB operand forwarding, load-use stall
// and a valid/ready ID/EX pipeline register.
module operand_fetch_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                   clk,
  input logic                   nrst,
  operand_fetch_stage_if.slave  bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic            rs1_used_s;
  logic            rs2_used_s;
  logic            rd_used_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            stall_s;
  logic            adv_s;

  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [31:0]     ex_instr_r;
  logic [XLEN-1:0] ex_rs1_val_r;
  logic [XLEN-1:0] ex_rs2_val_r;
  logic [4:0]      ex_rd_r;

  // Youngest producer wins; WB is needed because the regfile write lands next edge.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic            used,
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_wen,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            mem_wen,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_wen,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    if (!used || rs == 5'd0) begin
      val = {XLEN{1'b0}};
    end else if (ex_wen && ex_rd == rs) begin
      val = ex_data;
    end else if (mem_wen && mem_rd == rs) begin
      val = mem_data;
    end else if (wb_wen && wb_rd == rs) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  assign opcode_s = bus.if_instr[6:0];
  assign rs1_s    = bus.if_instr[19:15];
  assign rs2_s    = bus.if_instr[24:20];
  assign rd_s     = bus.if_instr[11:7];

  // Decode which register fields are real sources/destination for this opcode
  always_comb begin
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    rd_used_s  = 1'b1;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        rs1_used_s = 1'b0;
      end
      OPC_OP: begin
        rs2_used_s = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        rs2_used_s = 1'b1;
        rd_used_s  = 1'b0;
      end
      default: begin
        rs1_used_s = 1'b1;
      end
    endcase
  end

  // Operand selection through the forwarding network
  always_comb begin
    rs1_val_s = fwd_operand(rs1_used_s, rs1_s, bus.rf_rdata1,
                            bus.ex_fwd_wen, bus.ex_fwd_rd, bus.ex_fwd_data,
                            bus.mem_fwd_wen, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
    rs2_val_s = fwd_operand(rs2_used_s, rs2_s, bus.rf_rdata2,
                            bus.ex_fwd_wen, bus.ex_fwd_rd, bus.ex_fwd_data,
                            bus.mem_fwd_wen, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
  end

  // A load in EX cannot forward yet, so a consumer waits one beat for MEM
  assign stall_s = bus.if_valid && bus.ex_load && (bus.ex_fwd_rd != 5'd0) &&
                   ((rs1_used_s && rs1_s == bus.ex_fwd_rd) ||
                    (rs2_used_s && rs2_s == bus.ex_fwd_rd));

  assign adv_s        = !ex_valid_r || bus.ex_ready;
  assign bus.id_ready = bus.flush || (adv_s && !stall_s);

  assign bus.rf_raddr1  = rs1_s;
  assign bus.rf_raddr2  = rs2_s;
  assign bus.ex_valid   = ex_valid_r;
  assign bus.ex_pc      = ex_pc_r;
  assign bus.ex_instr   = ex_instr_r;
  assign bus.ex_rs1_val = ex_rs1_val_r;
  assign bus.ex_rs2_val = ex_rs2_val_r;
  assign bus.ex_rd      = ex_rd_r;

  // ID/EX pipeline register: flush, bubble, load, drain or hold
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= {XLEN{1'b0}};
      ex_instr_r   <= NOP_INSTR;
      ex_rs1_val_r <= {XLEN{1'b0}};
      ex_rs2_val_r <= {XLEN{1'b0}};
      ex_rd_r      <= 5'd0;
    end else if (bus.flush || (adv_s && stall_s)) begin
      ex_valid_r <= 1'b0;
      ex_instr_r <= NOP_INSTR;
    end else if (adv_s && bus.if_valid) begin
      ex_valid_r   <= 1'b1;
      ex_pc_r      <= bus.if_pc;
      ex_instr_r   <= bus.if_instr;
      ex_rs1_val_r <= rs1_val_s;
      ex_rs2_val_r <= rs2_val_s;
      ex_rd_r      <= rd_used_s ? rd_s : 5'd0;
    end else if (adv_s) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding priority, load-use stall,
// backpressure hold, x0 handling, flush and asynchronous reset.
module tb_operand_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_X6X5 = 32'h0002_8333; // add x6,x5,x0
  localparam logic [31:0] ADD_X8X7 = 32'h0013_8433; // add x8,x7,x1
  localparam logic [31:0] LUI_X7   = 32'h1234_53B7; // lui x7,0x12345
  localparam logic [31:0] SW_X0    = 32'h0001_2023; // sw x0,0(x2)
  localparam logic [31:0] ADDI_X9  = 32'h0000_0493; // addi x9,x0,0

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_errors;

  operand_fetch_stage_if #(.XLEN(32)) bus ();

  operand_fetch_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [4:0] rd);
    chk({tag, "_valid"}, {31'd0, bus.ex_valid}, {31'd0, v});
    chk({tag, "_pc"},    bus.ex_pc, pc);
    chk({tag, "_instr"}, bus.ex_instr, instr);
    chk({tag, "_rd"},    {27'd0, bus.ex_rd}, {27'd0, rd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    nrst = 1'b0;
    bus.if_valid = 1'b0;   bus.if_instr = NOP;      bus.if_pc = 32'd0;
    bus.rf_rdata1 = 32'd0; bus.rf_rdata2 = 32'd0;
    bus.ex_fwd_wen = 1'b0; bus.ex_load = 1'b0; bus.ex_fwd_rd = 5'd0; bus.ex_fwd_data = 32'd0;
    bus.mem_fwd_wen = 1'b0; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'd0;
    bus.wb_wen = 1'b0; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'd0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    step();
    chk_ex("reset", 1'b0, 32'd0, NOP, 5'd0);
    chk("reset_rs1", bus.ex_rs1_val, 32'd0);
    chk("reset_rs2", bus.ex_rs2_val, 32'd0);
    nrst = 1'b1;

    // Forwarding priority EX > MEM > WB > regfile
    bus.if_valid = 1'b1; bus.if_instr = ADD_X6X5; bus.if_pc = 32'h100;
    bus.ex_fwd_wen = 1'b1;  bus.ex_fwd_rd = 5'd5;  bus.ex_fwd_data = 32'h11;
    bus.mem_fwd_wen = 1'b1; bus.mem_fwd_rd = 5'd5; bus.mem_fwd_data = 32'h22;
    bus.wb_wen = 1'b1;      bus.wb_waddr = 5'd5;   bus.wb_wdata = 32'h33;
    bus.rf_rdata1 = 32'h44; bus.rf_rdata2 = 32'h55;
    #1;
    chk("t1_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("t1_raddr1", {27'd0, bus.rf_raddr1}, 32'd5);
    step();
    chk_ex("t1_ex", 1'b1, 32'h100, ADD_X6X5, 5'd6);
    chk("t1_rs1_ex", bus.ex_rs1_val, 32'h11);
    chk("t1_rs2_x0", bus.ex_rs2_val, 32'd0);
    bus.ex_fwd_wen = 1'b0; bus.if_pc = 32'h104;
    step();
    chk("t1_rs1_mem", bus.ex_rs1_val, 32'h22);
    chk("t1_pc2", bus.ex_pc, 32'h104);
    bus.mem_fwd_wen = 1'b0; bus.if_pc = 32'h108;
    step();
    chk("t1_rs1_wb", bus.ex_rs1_val, 32'h33);
    bus.wb_wen = 1'b0;
    step();
    chk("t1_rs1_rf", bus.ex_rs1_val, 32'h44);

    // Load-use stall then MEM forward
    bus.if_instr = ADD_X8X7; bus.if_pc = 32'h10C; bus.rf_rdata2 = 32'h77;
    bus.ex_load = 1'b1; bus.ex_fwd_rd = 5'd7;
    #1;
    chk("t2_id_ready_stall", {31'd0, bus.id_ready}, 32'd0);
    chk("t2_raddr2", {27'd0, bus.rf_raddr2}, 32'd1);
    step();
    chk("t2_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("t2_bubble_instr", bus.ex_instr, NOP);
    bus.ex_load = 1'b0;
    bus.mem_fwd_wen = 1'b1; bus.mem_fwd_rd = 5'd7; bus.mem_fwd_data = 32'hABCD;
    #1;
    chk("t2_id_ready_go", {31'd0, bus.id_ready}, 32'd1);
    step();
    chk_ex("t2_ex", 1'b1, 32'h10C, ADD_X8X7, 5'd8);
    chk("t2_rs1", bus.ex_rs1_val, 32'hABCD);
    chk("t2_rs2", bus.ex_rs2_val, 32'h77);
    bus.mem_fwd_wen = 1'b0;

    // Load in EX to x7, but consumer does not read x7 as a used source
    bus.ex_load = 1'b1; bus.ex_fwd_rd = 5'd7;
    bus.if_instr = LUI_X7; bus.if_pc = 32'h110;
    #1;
    chk("t3_lui_ready", {31'd0, bus.id_ready}, 32'd1);
    step();
    chk_ex("t3_lui", 1'b1, 32'h110, LUI_X7, 5'd7);
    bus.if_instr = SW_X0; bus.if_pc = 32'h114;
    #1;
    chk("t3_sw_ready", {31'd0, bus.id_ready}, 32'd1);
    step();
    chk_ex("t3_sw", 1'b1, 32'h114, SW_X0, 5'd0);
    chk("t3_sw_rs2", bus.ex_rs2_val, 32'd0);
    bus.ex_load = 1'b0;

    // Backpressure hold, with x0 source against all-ones forwarding data
    bus.ex_ready = 1'b0;
    bus.if_instr = ADDI_X9; bus.if_pc = 32'h118;
    bus.ex_fwd_wen = 1'b1;  bus.ex_fwd_rd = 5'd0;  bus.ex_fwd_data = 32'hFFFF_FFFF;
    bus.mem_fwd_wen = 1'b1; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'hFFFF_FFFF;
    bus.wb_wen = 1'b1;      bus.wb_waddr = 5'd0;   bus.wb_wdata = 32'hFFFF_FFFF;
    bus.rf_rdata1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_id_ready_hold", {31'd0, bus.id_ready}, 32'd0);
      step();
      chk_ex("t4_hold", 1'b1, 32'h114, SW_X0, 5'd0);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("t4_id_ready_release", {31'd0, bus.id_ready}, 32'd1);
    step();
    chk_ex("t5_addi", 1'b1, 32'h118, ADDI_X9, 5'd9);
    chk("t5_rs1_x0", bus.ex_rs1_val, 32'd0);

    // Flush while stalled and backpressured
    bus.ex_fwd_wen = 1'b0; bus.mem_fwd_wen = 1'b0; bus.wb_wen = 1'b0;
    bus.rf_rdata1 = 32'h44;
    bus.ex_ready = 1'b0; bus.ex_load = 1'b1; bus.ex_fwd_rd = 5'd7;
    bus.if_instr = ADD_X8X7; bus.if_pc = 32'h11C; bus.flush = 1'b1;
    #1;
    chk("t6_flush_ready", {31'd0, bus.id_ready}, 32'd1);
    step();
    chk("t6_flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("t6_flush_instr", bus.ex_instr, NOP);
    bus.flush = 1'b0; bus.ex_load = 1'b0; bus.ex_ready = 1'b1;
    step();
    chk_ex("t6_reload", 1'b1, 32'h11C, ADD_X8X7, 5'd8);
    chk("t6_reload_rs1", bus.ex_rs1_val, 32'h44);

    // Asynchronous reset mid-cycle
    #2;
    nrst = 1'b0;
    #1;
    chk_ex("t6_rst", 1'b0, 32'd0, NOP, 5'd0);
    chk("t6_rst_rs1", bus.ex_rs1_val, 32'd0);
    chk("t6_rst_rs2", bus.ex_rs2_val, 32'd0);
    nrst = 1'b1;
    step();
    chk_ex("t6_after_rst", 1'b1, 32'h11C, ADD_X8X7, 5'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
